bram_dp_scrub: RTL
==================

BRAM_DP_SCRUB -- requirements
Module: bram_dp_scrub

Interface
REQ-001 Parameter ADDR_WIDTH SHALL default to 10 and set the word address width; depth is 2**ADDR_WIDTH words.
REQ-002 Parameter DATA_WIDTH SHALL default to 32 and set the word width; it is a multiple of 8.
REQ-003 Parameter OUT_REG SHALL default to 0; 0 gives 1-cycle read latency, 1 adds an output register for 2-cycle latency.
REQ-004 Parameter WRITE_FIRST SHALL default to 0; it selects cross-port same-address read data (0 = old, 1 = new).
REQ-005 The block SHALL use one clock, clk; reset rst SHALL be asynchronous and active-high.
REQ-006 Ports SHALL be, one per line:
- clk, input, 1, clock
- rst, input, 1, asynchronous active-high reset
- clr_req, input, 1, request to zero the whole memory
- busy, output, 1, clear in progress
- req_a, input, 1, port A request valid
- ready_a, output, 1, port A can accept
- we_a, input, 1, port A write (1) or read (0)
- wstrb_a, input, DATA_WIDTH/8, port A byte enables
- addr_a, input, ADDR_WIDTH, port A word address
- din_a, input, DATA_WIDTH, port A write data
- rvalid_a, output, 1, port A read data valid
- dout_a, output, DATA_WIDTH, port A read data
- req_b, we_b, wstrb_b, addr_b, din_b, ready_b, rvalid_b, dout_b: port B, identical to port A.

Function
REQ-007 The clear FSM SHALL have two states, CLEAR and IDLE; busy = (state == CLEAR).
REQ-008 In CLEAR, a counter SHALL write all-zero to word cnt each cycle, from 0 to 2**ADDR_WIDTH-1, then go to IDLE; CLEAR lasts exactly 2**ADDR_WIDTH cycles.
REQ-009 In IDLE, clr_req = 1 SHALL move the FSM to CLEAR with cnt = 0 on the next edge; clr_req while in CLEAR is ignored and does not restart the counter.
REQ-010 ready_a and ready_b SHALL both equal !busy, combinationally from the state.
REQ-011 An access is accepted on a port when req & ready is high at a rising edge; no request is accepted while busy.
REQ-012 An accepted write SHALL update only the byte lanes whose wstrb bit is 1; wstrb = 0 performs no write.
REQ-013 An accepted read SHALL raise rvalid for exactly one cycle, 1 cycle later (OUT_REG = 0) or 2 cycles later (OUT_REG = 1); accepted writes never raise rvalid.
REQ-014 dout SHALL hold its last value while rvalid = 0; both ports are fully pipelined at one read per cycle per port.
REQ-015 If both ports write the same address in one cycle, port A's byte SHALL win where both strobes are set; bytes with disjoint strobes SHALL both be applied.
REQ-016 If one port reads an address while the other writes it in the same cycle, the read SHALL return the pre-write word when WRITE_FIRST = 0, and the post-write word (bytes merged per REQ-012/015) when WRITE_FIRST = 1.
REQ-017 Reads accepted before entering CLEAR SHALL still deliver rvalid with the pre-clear data.
REQ-018 Memory SHALL map to block RAM; the write-first bypass and collision logic SHALL sit outside the RAM array.

Reset
REQ-019 While rst is high: FSM = CLEAR, cnt = 0, busy = 1, ready_a/b = 0, rvalid_a/b = 0, dout_a/b = 0, and all in-flight read pipeline stages are discarded.
REQ-020 Deasserting rst SHALL start a full clear, so memory reads as zero after every reset, including a reset asserted mid-operation or mid-clear.

Verification (bench uses ADDR_WIDTH = 4, DATA_WIDTH = 32)
REQ-021 Release rst -> busy = 1 for exactly 16 cycles, then ready_a/b = 1; a read of every address returns 0x00000000.
REQ-022 Port A writes 0xDEADBEEF to addr 3 with wstrb = 0xF, then writes 0x11223344 with wstrb = 0x5 -> a read of addr 3 returns 0xDE22BE44, with rvalid at +1 cycle (OUT_REG = 0) and +2 cycles (OUT_REG = 1).
REQ-023 Same cycle: A writes 0xAAAAAAAA with wstrb 0x3 and B writes 0xBBBBBBBB with wstrb 0xE, both to addr 5 -> addr 5 reads 0xBBBBAAAA.
REQ-024 Addr 7 holds 0x0; same cycle: A writes 0x12345678 (wstrb 0xF) and B reads addr 7 -> dout_b = 0x00000000 with WRITE_FIRST = 0, and 0x12345678 with WRITE_FIRST = 1.
REQ-025 Issue a read on addr 2 (holding 0x55), then pulse clr_req on the next cycle -> rvalid delivers 0x55, busy is high for 16 cycles, and addr 2 then reads 0.
REQ-026 Assert rst for 1 cycle mid-clear and while a read is in flight -> rvalid and dout go to 0 immediately, no stale rvalid appears, and a full 16-cycle clear restarts.

Source files
------------

// File: rtl/bram_dp_scrub.sv
// True dual-port byte-writable block RAM with a self-scrubbing clear engine.
// Reset or clr_req zeroes every word; the write-first bypass lives outside the array.
module bram_dp_scrub #(
   parameter int ADDR_WIDTH  = 10,
   parameter int DATA_WIDTH  = 32,
   parameter int OUT_REG     = 0,
   parameter int WRITE_FIRST = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr_req,
   output logic                    busy,
   input  logic                    req_a,
   output logic                    ready_a,
   input  logic                    we_a,
   input  logic [DATA_WIDTH/8-1:0] wstrb_a,
   input  logic [ADDR_WIDTH-1:0]   addr_a,
   input  logic [DATA_WIDTH-1:0]   din_a,
   output logic                    rvalid_a,
   output logic [DATA_WIDTH-1:0]   dout_a,
   input  logic                    req_b,
   output logic                    ready_b,
   input  logic                    we_b,
   input  logic [DATA_WIDTH/8-1:0] wstrb_b,
   input  logic [ADDR_WIDTH-1:0]   addr_b,
   input  logic [DATA_WIDTH-1:0]   din_b,
   output logic                    rvalid_b,
   output logic [DATA_WIDTH-1:0]   dout_b
);

   localparam int NB    = DATA_WIDTH / 8;
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic {CLEAR, IDLE} state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;

   logic                    rd_en_a, rd_en_b, wr_a, wr_b;
   logic [ADDR_WIDTH-1:0]   wa_addr, wb_addr;
   logic [DATA_WIDTH-1:0]   wa_data, wb_data;
   logic [NB-1:0]           wa_strb, wb_strb;

   logic [DATA_WIDTH-1:0]   mem [DEPTH];
   logic [DATA_WIDTH-1:0]   ram_a_q, ram_b_q;

   logic                    rvalid1_a_q, rvalid1_a_d, rvalid1_b_q, rvalid1_b_d;
   logic [DATA_WIDTH-1:0]   byp_mask_a_q, byp_mask_a_d, byp_data_a_q, byp_data_a_d;
   logic [DATA_WIDTH-1:0]   byp_mask_b_q, byp_mask_b_d, byp_data_b_q, byp_data_b_d;
   logic [DATA_WIDTH-1:0]   merged_a, merged_b;

   function automatic logic [DATA_WIDTH-1:0] byte_mask(input logic [NB-1:0] s);
      logic [DATA_WIDTH-1:0] m;
      m = '0;
      for (int i = 0; i < NB; i++) m[i*8 +: 8] = {8{s[i]}};
      return m;
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         CLEAR: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '1) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         IDLE: begin
            if (clr_req) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         default: state_d = CLEAR;
      endcase
   end

   assign busy    = (state_q == CLEAR);
   assign ready_a = !busy;
   assign ready_b = !busy;

   assign rd_en_a = req_a && ready_a && !we_a;
   assign rd_en_b = req_b && ready_b && !we_b;
   assign wr_a    = req_a && ready_a && we_a;
   assign wr_b    = req_b && ready_b && we_b;

   // Port A's write path doubles as the scrub port while clearing.
   always_comb begin
      wa_addr = busy ? cnt_q : addr_a;
      wa_data = busy ? '0 : din_a;
      wa_strb = busy ? '1 : (wr_a ? wstrb_a : '0);
      wb_addr = addr_b;
      wb_data = din_b;
      wb_strb = wr_b ? wstrb_b : '0;
      if (wb_addr == wa_addr) wb_strb = wb_strb & ~wa_strb;
   end

   always_comb begin
      rvalid1_a_d  = rd_en_a;
      rvalid1_b_d  = rd_en_b;
      byp_mask_a_d = '0;
      byp_mask_b_d = '0;
      byp_data_a_d = wb_data;
      byp_data_b_d = wa_data;
      if (WRITE_FIRST != 0 && rd_en_a && addr_a == wb_addr) byp_mask_a_d = byte_mask(wb_strb);
      if (WRITE_FIRST != 0 && rd_en_b && addr_b == wa_addr) byp_mask_b_d = byte_mask(wa_strb);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= CLEAR;
         cnt_q        <= '0;
         rvalid1_a_q  <= 1'b0;
         rvalid1_b_q  <= 1'b0;
         byp_mask_a_q <= '0;
         byp_mask_b_q <= '0;
         byp_data_a_q <= '0;
         byp_data_b_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         rvalid1_a_q  <= rvalid1_a_d;
         rvalid1_b_q  <= rvalid1_b_d;
         byp_mask_a_q <= byp_mask_a_d;
         byp_mask_b_q <= byp_mask_b_d;
         byp_data_a_q <= byp_data_a_d;
         byp_data_b_q <= byp_data_b_d;
      end
   end

   // Plain read-first RAM array, no reset, so it infers block RAM.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NB; i++) begin
         if (wa_strb[i]) mem[wa_addr][i*8 +: 8] <= wa_data[i*8 +: 8];
         if (wb_strb[i]) mem[wb_addr][i*8 +: 8] <= wb_data[i*8 +: 8];
      end
      if (rd_en_a) ram_a_q <= mem[addr_a];
      if (rd_en_b) ram_b_q <= mem[addr_b];
   end

   assign merged_a = (ram_a_q & ~byp_mask_a_q) | (byp_data_a_q & byp_mask_a_q);
   assign merged_b = (ram_b_q & ~byp_mask_b_q) | (byp_data_b_q & byp_mask_b_q);

   generate
      if (OUT_REG != 0) begin : g_oreg
         logic                  rvalid2_a_q, rvalid2_b_q;
         logic [DATA_WIDTH-1:0] dout_a_q, dout_a_d, dout_b_q, dout_b_d;

         always_comb begin
            dout_a_d = rvalid1_a_q ? merged_a : dout_a_q;
            dout_b_d = rvalid1_b_q ? merged_b : dout_b_q;
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               rvalid2_a_q <= 1'b0;
               rvalid2_b_q <= 1'b0;
               dout_a_q    <= '0;
               dout_b_q    <= '0;
            end else begin
               rvalid2_a_q <= rvalid1_a_q;
               rvalid2_b_q <= rvalid1_b_q;
               dout_a_q    <= dout_a_d;
               dout_b_q    <= dout_b_d;
            end
         end

         assign rvalid_a = rvalid2_a_q;
         assign rvalid_b = rvalid2_b_q;
         assign dout_a   = dout_a_q;
         assign dout_b   = dout_b_q;
      end else begin : g_noreg
         // hold_q remembers the last delivered word so dout stays put between reads.
         logic [DATA_WIDTH-1:0] hold_a_q, hold_a_d, hold_b_q, hold_b_d;

         always_comb begin
            hold_a_d = rvalid1_a_q ? merged_a : hold_a_q;
            hold_b_d = rvalid1_b_q ? merged_b : hold_b_q;
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               hold_a_q <= '0;
               hold_b_q <= '0;
            end else begin
               hold_a_q <= hold_a_d;
               hold_b_q <= hold_b_d;
            end
         end

         assign rvalid_a = rvalid1_a_q;
         assign rvalid_b = rvalid1_b_q;
         assign dout_a   = hold_a_d;
         assign dout_b   = hold_b_d;
      end
   endgenerate

endmodule
